// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access sequencer:
// FSM state encoding and fault cause codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_BUSERR   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores over a req/ack bus, stalls the
// pipeline while an access is outstanding and reports faults.
// Ports: i_clk/i_resetn; MEM-stage request i_mem_*/i_flush;
// bus o_bus_*/i_bus_*; pipeline o_stall, o_done, o_rd_dmem,
// o_fault, o_fault_cause.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int P_TIMEOUT = 16,
  parameter int P_CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_flush,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rd_dmem,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  localparam logic [P_CNT_W-1:0] TO_LAST =
    P_CNT_W'(P_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rd_q, rd_d;
  logic               we_q, we_d;
  logic               flushed_q, flushed_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [1:0]         cause_q, cause_d;

  logic op, misal, flushed;

  assign op      = (i_mem_read | i_mem_write) & ~i_flush;
  assign misal   = |i_mem_addr[1:0];
  // A flush seen in the completing cycle squashes too.
  assign flushed = flushed_q | i_flush;

  // Combinational so the detection cycle is already stalled.
  assign o_stall = (state_q == S_IDLE && op && !misal)
                 | (state_q == S_ACCESS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    flushed_d = flushed_q;
    cause_d   = FC_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (op && misal) begin
          state_d = S_FAULT;
          cause_d = FC_MISALIGN;
        end else if (op) begin
          state_d   = S_ACCESS;
          addr_d    = i_mem_addr;
          wdata_d   = i_mem_wdata;
          we_d      = i_mem_write;
          cnt_d     = '0;
          flushed_d = 1'b0;
        end
      end
      S_ACCESS: begin
        cnt_d     = cnt_q + 1'b1;
        flushed_d = flushed;
        if (i_bus_err) begin
          state_d = flushed ? S_IDLE : S_FAULT;
          cause_d = flushed ? FC_NONE : FC_BUSERR;
        end else if (i_bus_ack) begin
          state_d = flushed ? S_IDLE : S_DONE;
          if (!flushed && !we_q) rd_d = i_bus_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d = flushed ? S_IDLE : S_FAULT;
          cause_d = flushed ? FC_NONE : FC_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_d   = (state_d == S_ACCESS);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      flushed_q <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= FC_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      flushed_q <= flushed_d;
      req_q     <= req_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  assign o_bus_req     = req_q;
  assign o_bus_we      = we_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_done        = done_q;
  assign o_rd_dmem     = rd_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;

endmodule
